eth_rx_fcs_check: RTL and testbench



---
 rtl/eth_rx_fcs_check.sv | 154 +++++++++++++++
 tb/tb_eth_rx_fcs_check.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_fcs_check.sv
// RMII receive FCS stage: packs dibits into bytes, checks the CRC-32 residue and strips
// the trailing FCS through a 4-byte delay line, then reports per-frame status.
module eth_rx_fcs_check #(
    parameter int ETH_MTU = 1518,
    parameter int ETH_MIN = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        axi_rx_valid,
    input  logic [1:0]  axi_rx_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_first,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [10:0] frame_len
);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] EMIT_CAP    = 11'(ETH_MTU - 4);
    localparam logic [10:0] MTU_LEN     = 11'(ETH_MTU);
    localparam logic [10:0] MIN_LEN     = 11'(ETH_MIN);
    localparam logic [10:0] CNT_SAT     = 11'h7FF;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        consume, finish;
    logic [1:0]  dib_cnt_p0;
    logic [5:0]  byte_sh_p0;
    logic [10:0] byte_cnt_p0;
    logic [31:0] crc_p0;
    logic [31:0] crc_base;
    logic [31:0] crc_next;
    logic        byte_done;
    logic [7:0]  new_byte;
    logic [31:0] dly_p1;
    logic [2:0]  fill_p1;
    logic [10:0] emit_cnt_p1;
    logic        crc_good, len_good;

    // Reflected CRC-32 advanced by one dibit, LSB first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c_in, input logic [1:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        consume = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (axi_rx_valid) begin
                    state_d = RECV;
                    consume = 1'b1;
                end
            end
            RECV: begin
                if (axi_rx_valid) begin
                    consume = 1'b1;
                end else begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The first dibit of a frame is folded into a freshly initialised register.
    assign crc_base  = (state_q == IDLE) ? CRC_INIT : crc_p0;
    assign crc_next  = crc_dibit(crc_base, axi_rx_data);
    assign byte_done = consume && (dib_cnt_p0 == 2'd3);
    assign new_byte  = {axi_rx_data, byte_sh_p0};
    assign crc_good  = (crc_p0 == CRC_RESIDUE);
    assign len_good  = (byte_cnt_p0 >= MIN_LEN) && (byte_cnt_p0 <= MTU_LEN);

    // Stage p0: dibit packing, byte count and CRC
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dib_cnt_p0  <= 2'd0;
            byte_sh_p0  <= 6'd0;
            byte_cnt_p0 <= 11'd0;
            crc_p0      <= 32'd0;
        end else if (consume) begin
            dib_cnt_p0 <= dib_cnt_p0 + 2'd1;
            crc_p0     <= crc_next;
            case (dib_cnt_p0)
                2'd0:    byte_sh_p0[1:0] <= axi_rx_data;
                2'd1:    byte_sh_p0[3:2] <= axi_rx_data;
                2'd2:    byte_sh_p0[5:4] <= axi_rx_data;
                default: byte_sh_p0      <= byte_sh_p0;
            endcase
            if (byte_done && byte_cnt_p0 != CNT_SAT) byte_cnt_p0 <= byte_cnt_p0 + 11'd1;
        end else if (finish) begin
            dib_cnt_p0  <= 2'd0;
            byte_cnt_p0 <= 11'd0;
        end
    end

    // Stage p1: FCS delay line, byte emission and frame status
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dly_p1      <= 32'd0;
            fill_p1     <= 3'd0;
            emit_cnt_p1 <= 11'd0;
            out_valid   <= 1'b0;
            out_data    <= 8'd0;
            out_first   <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_len   <= 11'd0;
        end else begin
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            frame_done <= 1'b0;
            if (byte_done) begin
                dly_p1 <= {dly_p1[23:0], new_byte};
                if (fill_p1 != 3'd4) begin
                    fill_p1 <= fill_p1 + 3'd1;
                end else if (emit_cnt_p1 < EMIT_CAP) begin
                    out_valid   <= 1'b1;
                    out_data    <= dly_p1[31:24];
                    out_first   <= (emit_cnt_p1 == 11'd0);
                    emit_cnt_p1 <= emit_cnt_p1 + 11'd1;
                end
            end
            if (finish) begin
                frame_done  <= 1'b1;
                frame_ok    <= crc_good && (dib_cnt_p0 == 2'd0) && len_good;
                frame_len   <= emit_cnt_p1;
                fill_p1     <= 3'd0;
                emit_cnt_p1 <= 11'd0;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: frames are built with a bench-computed FCS, and
// expected bytes and status are queued at stimulus time and popped as the DUT produces them.
module tb_eth_rx_fcs_check;

    logic        clk = 1'b0;
    logic        rstn;
    logic        axi_rx_valid;
    logic [1:0]  axi_rx_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_first;
    logic        frame_done;
    logic        frame_ok;
    logic [10:0] frame_len;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int exp_done_cnt = 0;

    logic [7:0]  frm[$];
    logic [8:0]  exp_byte_q[$];
    logic [11:0] exp_stat_q[$];

    eth_rx_fcs_check #(.ETH_MTU(1518), .ETH_MIN(64)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .axi_rx_valid (axi_rx_valid),
        .axi_rx_data  (axi_rx_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_first    (out_first),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .frame_len    (frame_len)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial Ethernet FCS over the current frame buffer.
    function automatic logic [31:0] fcs_frm();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (frm[k]) begin
            for (int i = 0; i < 8; i++) begin
                if (c[0] ^ frm[k][i]) c = (c >> 1) ^ 32'hEDB8_8320;
                else                  c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic build(input int n, input int off);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'(i + off));
    endtask

    task automatic add_fcs();
        logic [31:0] f;
        f = fcs_frm();
        for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
    endtask

    task automatic expect_bytes(input int n_emit);
        for (int k = 0; k < n_emit; k++) exp_byte_q.push_back({(k == 0), frm[k]});
    endtask

    task automatic expect_frame(input int n_emit, input logic ok);
        expect_bytes(n_emit);
        exp_stat_q.push_back({ok, 11'(n_emit)});
        exp_done_cnt++;
    endtask

    task automatic send(input int nbytes, input int extra);
        for (int k = 0; k < nbytes; k++) begin
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                axi_rx_valid = 1'b1;
                axi_rx_data  = frm[k][2*n +: 2];
            end
        end
        for (int e = 0; e < extra; e++) begin
            @(negedge clk);
            axi_rx_valid = 1'b1;
            axi_rx_data  = 2'b01;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            axi_rx_valid = 1'b0;
            axi_rx_data  = 2'b00;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_valid"},  32'(out_valid),  32'd0);
        check({tag, "_out_data"},   32'(out_data),   32'd0);
        check({tag, "_out_first"},  32'(out_first),  32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_frame_ok"},   32'(frame_ok),   32'd0);
        check({tag, "_frame_len"},  32'(frame_len),  32'd0);
    endtask

    always @(negedge clk) begin
        logic [8:0]  e;
        logic [11:0] s;
        if (rstn === 1'b1) begin
            if (out_valid) begin
                if (exp_byte_q.size() == 0) begin
                    check("extra_byte", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_byte_q.pop_front();
                    check("out_data",  32'(out_data),  32'(e[7:0]));
                    check("out_first", 32'(out_first), 32'(e[8]));
                end
            end
            if (frame_done) begin
                done_cnt++;
                if (exp_stat_q.size() == 0) begin
                    check("extra_done", 32'(frame_done), 32'd0);
                end else begin
                    s = exp_stat_q.pop_front();
                    check("frame_ok",  32'(frame_ok),  32'(s[11]));
                    check("frame_len", 32'(frame_len), 32'(s[10:0]));
                end
            end
        end
    end

    initial begin
        rstn         = 1'b0;
        axi_rx_valid = 1'b0;
        axi_rx_data  = 2'b00;
        repeat (3) @(negedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk);
        #5 rstn = 1'b1;
        idle(2);

        // good 64-byte frame
        build(60, 0); add_fcs();
        expect_frame(60, 1'b1);
        send(64, 0); idle(3);

        // corrupted data bit in byte 20
        build(60, 0); add_fcs();
        frm[20] = frm[20] ^ 8'h01;
        expect_frame(60, 1'b0);
        send(64, 0); idle(3);

        // 32-byte runt with valid FCS
        build(28, 0); add_fcs();
        expect_frame(28, 1'b0);
        send(32, 0); idle(3);

        // good frame plus two trailing dibits
        build(60, 8'h10); add_fcs();
        expect_frame(60, 1'b0);
        send(64, 2); idle(3);

        // frame shorter than the FCS
        build(2, 8'hAA);
        expect_frame(0, 1'b0);
        send(2, 0); idle(3);

        // back-to-back good frames with a single idle cycle
        build(60, 8'h80); add_fcs();
        expect_frame(60, 1'b1);
        expect_frame(60, 1'b1);
        send(64, 0); idle(1);
        send(64, 0); idle(3);

        // reset in the middle of a frame after 30 bytes
        build(60, 8'h40); add_fcs();
        expect_bytes(26);
        send(30, 0);
        @(negedge clk);
        #5 rstn = 1'b0;
        axi_rx_valid = 1'b0;
        axi_rx_data  = 2'b00;
        #1 check_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        #1 check_outputs_zero("midreset_hold");
        @(negedge clk);
        #5 rstn = 1'b1;
        idle(2);

        build(60, 8'hC0); add_fcs();
        expect_frame(60, 1'b1);
        send(64, 0); idle(20);

        check("byte_queue_left", 32'(exp_byte_q.size()), 32'd0);
        check("status_queue_left", 32'(exp_stat_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'(exp_done_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
